// File: rtl/hx8352_bus_arbiter.sv
// rtl/hx8352_bus_arbiter.sv - two-port burst arbiter in front of the HX8352 bus controller
// Grants whole bursts, issues one bus_step per word and frames lcd_cs with setup/hold.
module hx8352_bus_arbiter #(
    parameter int FIXED_PRIO  = 0,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rs,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  req_ready,
    output logic [1:0]  grant,
    output logic [15:0] bus_data,
    output logic        bus_rs,
    output logic        bus_step,
    input  logic        bus_busy,
    output logic        lcd_cs,
    output logic        ack_timeout
);

    localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_MAX = (MAX_SH > ACK_TIMEOUT) ? MAX_SH : ACK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] ACK_END   = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_ACK,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    grant_q, grant_d;
    logic          ptr_q, ptr_d;
    logic          last_q, last_d;
    logic [15:0]   bus_data_q, bus_data_d;
    logic          bus_rs_q, bus_rs_d;
    logic          bus_step_q, bus_step_d;
    logic          lcd_cs_q, lcd_cs_d;
    logic          ack_timeout_q, ack_timeout_d;

    // Owner index is grant bit 1; only meaningful while a burst is granted.
    logic          gidx;
    logic          own_valid;
    logic          own_rs;
    logic          own_last;
    logic [15:0]   own_data;
    logic          win;

    assign gidx      = grant_q[1];
    assign own_valid = req_valid[gidx];
    assign own_rs    = req_rs[gidx];
    assign own_last  = req_last[gidx];
    assign own_data  = gidx ? req_data[31:16] : req_data[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            grant_q       <= 2'b00;
            ptr_q         <= 1'b0;
            last_q        <= 1'b0;
            bus_data_q    <= 16'h0000;
            bus_rs_q      <= 1'b0;
            bus_step_q    <= 1'b0;
            lcd_cs_q      <= 1'b1;
            ack_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            last_q        <= last_d;
            bus_data_q    <= bus_data_d;
            bus_rs_q      <= bus_rs_d;
            bus_step_q    <= bus_step_d;
            lcd_cs_q      <= lcd_cs_d;
            ack_timeout_q <= ack_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        last_d        = last_q;
        bus_data_d    = bus_data_q;
        bus_rs_d      = bus_rs_q;
        bus_step_d    = 1'b0;
        lcd_cs_d      = lcd_cs_q;
        ack_timeout_d = ack_timeout_q;
        req_ready     = 2'b00;
        win           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    if (FIXED_PRIO != 0) begin
                        win = ~req_valid[0];
                    end else begin
                        win = req_valid[ptr_q] ? ptr_q : ~ptr_q;
                    end
                    grant_d  = win ? 2'b10 : 2'b01;
                    lcd_cs_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_END) begin
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ISSUE: begin
                // grant_q is one-hot, so it doubles as the ready mask of the owner.
                if (own_valid && !bus_busy) begin
                    req_ready  = grant_q;
                    bus_data_d = own_data;
                    bus_rs_d   = own_rs;
                    last_d     = own_last;
                    bus_step_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                if (bus_busy) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == ACK_END) begin
                    ack_timeout_d = 1'b1;
                    state_d       = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (!bus_busy) begin
                    if (last_q) begin
                        ptr_d   = ~gidx;
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_END) begin
                    lcd_cs_d = 1'b1;
                    grant_d  = 2'b00;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign grant       = grant_q;
    assign bus_data    = bus_data_q;
    assign bus_rs      = bus_rs_q;
    assign bus_step    = bus_step_q;
    assign lcd_cs      = lcd_cs_q;
    assign ack_timeout = ack_timeout_q;

endmodule
